local_inject_queue: RTL
=======================

LOCAL_INJECT_QUEUE -- requirements
Module: local_inject_queue

Interface
REQ-001 Parameter DATA_W, default 32, payload width.
REQ-002 Parameter DEPTH, default 4, queue entries; power of two, 2..16.
REQ-003 Parameter CUR_X, default 0, this node X coordinate (4 bits).
REQ-004 Parameter CUR_Y, default 0, this node Y coordinate (4 bits).
REQ-005 Parameter STARVE_LIM, default 16, head-blocked cycles before starve asserts, 1..255.
REQ-006 clk  input  1  the single clock; all state updates on its rising edge.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 enq_valid  input  1  core offers a flit.
REQ-009 enq_ready  output  1  queue accepts; equals not-full.
REQ-010 enq_flitid  input  2  FLITID field.
REQ-011 enq_dst_x, enq_dst_y  input  4 each  destination coordinates.
REQ-012 enq_data  input  DATA_W  payload.
REQ-013 slot_free  input  1  router has an idle input slot this cycle.
REQ-014 throttle  input  1  injection inhibit.
REQ-015 dout  output  24+DATA_W  head flit {PKTID[6],FLITID[2],TIME[8],POS_X[4],POS_Y[4],DATA}.
REQ-016 dout_valid  output  1  head present.
REQ-017 pv_out  output  5  productive-port vector, bit4 LOCAL, 3 N, 2 S, 1 E, 0 W.
REQ-018 inj_fire  output  1  head injected this cycle.
REQ-019 starve  output  1  head blocked for at least STARVE_LIM cycles.

Function
REQ-020 Enqueue occurs on a rising edge with enq_valid=1 and enq_ready=1; enq_ready=0 when count==DEPTH, even if a dequeue occurs in the same cycle.
REQ-021 Enqueue stores PKTID from a 6-bit counter, which then increments and wraps 63->0; TIME is stored as 0.
REQ-022 Storage is circular FIFO with wrapping read/write pointers and a count register of log2(DEPTH)+1 bits.
REQ-023 dout_valid=1 iff count>0; dout and pv_out are combinational from the head entry; dout=0 and pv_out=0 when empty.
REQ-024 A flit enqueued into an empty queue is visible at the head the cycle after its enqueue edge; there is no same-cycle bypass.
REQ-025 inj_fire = dout_valid & slot_free & ~throttle; on a fire edge the head is popped and count decrements.
REQ-026 Simultaneous enqueue and fire (not full) leaves count unchanged.
REQ-027 Every resident entry not popped on an edge has its TIME incremented by 1 on that edge, saturating at 255; a newly written entry is not incremented on its write edge.
REQ-028 pv_out bit1 is set when dst_x>CUR_X and bit0 when dst_x<CUR_X; bit3 is set when dst_y>CUR_Y and bit2 when dst_y<CUR_Y; when both coordinates match, pv_out=5'b10000.
REQ-029 The starve counter (8 bits) increments, saturating, on each edge where dout_valid=1 and inj_fire=0, and clears on a fire or when the queue is empty.
REQ-030 starve=1 when starve counter >= STARVE_LIM; starve is a level output, not a pulse.

Reset
REQ-031 While reset=0: count, pointers, PKTID counter and starve counter are 0; enq_ready=1; dout_valid, inj_fire and starve are 0; dout and pv_out are 0.
REQ-032 Reset asserted mid-operation discards all queued flits immediately, with no injection on that edge.
REQ-033 After reset deasserts, the first edge accepts an enqueue.

Verification
REQ-034 CUR=(1,1); enqueue dst (2,1) data 0xA with slot_free=1 -> the next cycle shows dout_valid=1, pv_out=00010, TIME=0 and PKTID=0, and inj_fire=1 pops the flit.
REQ-035 slot_free=0, enqueue dst (1,1) and hold for 5 cycles -> TIME reads 0,1,2,3,4 and pv_out=10000; with STARVE_LIM=4, starve rises on the 5th head cycle and clears after fire.
REQ-036 DEPTH=4, slot_free=0, 5 enqueues offered -> enq_ready falls after the 4th, and the 5th is held until the first pop.
REQ-037 Full queue, enq_valid=1 and slot_free=1 in the same cycle -> one pop and no enqueue that edge; count goes 4->3, then 3->3 on the following edge with both active.
REQ-038 Hold a flit for 300 cycles -> TIME saturates at 255; 64 enqueues -> PKTID wraps 63->0.
REQ-039 Drive reset low with 3 flits queued -> dout_valid=0 and enq_ready=1 asynchronously; the PKTID of the next flit is 0.

Source files
------------

// File: rtl/local_inject_queue.sv
// -----------------------------------------------------------------------------
// local_inject_queue
//
// Holds flits offered by the local core until the router has an idle input
// slot. The queue is a small circular FIFO. Each entry carries a packet id,
// the core's FLITID, an age (TIME) and the destination coordinates.
// The head entry is presented combinationally, together with the vector of
// productive output ports toward its destination. A starvation monitor flags
// a head that has waited too long.
//
// Ports
//   clk          rising-edge clock for all state
//   reset        asynchronous, active-low reset
//   enq_valid    core offers a flit this cycle
//   enq_ready    queue can accept (not full)
//   enq_flitid   2-bit FLITID of the offered flit
//   enq_dst_x/y  destination coordinates of the offered flit
//   enq_data     payload of the offered flit
//   slot_free    router has an idle input slot this cycle
//   throttle     injection inhibit
//   dout         head flit {PKTID[6],FLITID[2],TIME[8],POS_X[4],POS_Y[4],DATA}
//   dout_valid   queue is not empty
//   pv_out       productive ports of the head: {LOCAL,N,S,E,W}
//   inj_fire     head is injected (popped) on the coming edge
//   starve       head has been blocked for at least STARVE_LIM cycles
// -----------------------------------------------------------------------------
module local_inject_queue #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned DEPTH      = 4,
  parameter logic [3:0]  CUR_X      = 4'd0,
  parameter logic [3:0]  CUR_Y      = 4'd0,
  parameter int unsigned STARVE_LIM = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enq_valid,
  output logic              enq_ready,
  input  logic [1:0]        enq_flitid,
  input  logic [3:0]        enq_dst_x,
  input  logic [3:0]        enq_dst_y,
  input  logic [DATA_W-1:0] enq_data,
  input  logic              slot_free,
  input  logic              throttle,
  output logic [DATA_W+23:0] dout,
  output logic              dout_valid,
  output logic [4:0]        pv_out,
  output logic              inj_fire,
  output logic              starve
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
  localparam logic [7:0]    STARVE_THR = 8'(STARVE_LIM);

  // Field order matches the dout layout, so the head entry drives dout as-is.
  typedef struct packed {
    logic [5:0]        pktid;
    logic [1:0]        flitid;
    logic [7:0]        tstamp;
    logic [3:0]        dst_x;
    logic [3:0]        dst_y;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [5:0]      pktid_cnt;
  logic [7:0]      starve_cnt;

  logic            do_enq;
  entry_t          new_entry;
  entry_t          head;

  // ---------------------------------------------------------------------------
  // Handshake and head presentation
  // ---------------------------------------------------------------------------
  // Full blocks enqueue even when the head pops in the same cycle; this keeps
  // enq_ready independent of slot_free/throttle.
  assign enq_ready  = (count != FULL_COUNT);
  assign dout_valid = (count != '0);
  assign inj_fire   = dout_valid & slot_free & ~throttle;
  assign do_enq     = enq_valid & enq_ready;

  assign head = mem[rd_ptr];
  assign dout = dout_valid ? head : '0;

  always_comb begin
    new_entry        = '0;
    new_entry.pktid  = pktid_cnt;
    new_entry.flitid = enq_flitid;
    new_entry.tstamp = 8'd0;
    new_entry.dst_x  = enq_dst_x;
    new_entry.dst_y  = enq_dst_y;
    new_entry.data   = enq_data;
  end

  // Productive ports: E/W from X, N/S from Y, LOCAL only when both match.
  // NOTE: every output of an always_comb block gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    pv_out = 5'b00000;
    if (dout_valid) begin
      if (head.dst_x > CUR_X) pv_out[1] = 1'b1;
      if (head.dst_x < CUR_X) pv_out[0] = 1'b1;
      if (head.dst_y > CUR_Y) pv_out[3] = 1'b1;
      if (head.dst_y < CUR_Y) pv_out[2] = 1'b1;
      if ((head.dst_x == CUR_X) && (head.dst_y == CUR_Y)) pv_out = 5'b10000;
    end
  end

  assign starve = (starve_cnt >= STARVE_THR);

  // ---------------------------------------------------------------------------
  // Entry storage and ageing
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset. Validity is tracked solely by count
  // and the pointers, and dout is masked while empty, so stale contents are
  // never observable; leaving it unreset keeps it plain flops/RAM.
  // Entries outside the occupied window also age. That is harmless because
  // every write starts TIME again from 0.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (do_enq && (AW'(i) == wr_ptr)) begin
        mem[i] <= new_entry;
      end else if (mem[i].tstamp != 8'hFF) begin
        mem[i].tstamp <= mem[i].tstamp + 8'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Pointers, occupancy, packet id and starvation counter
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of the
  // order of the statements.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      pktid_cnt  <= 6'd0;
      starve_cnt <= 8'd0;
    end else begin
      if (do_enq) begin
        wr_ptr    <= wr_ptr + AW'(1);
        pktid_cnt <= pktid_cnt + 6'd1;
      end
      if (inj_fire) begin
        rd_ptr <= rd_ptr + AW'(1);
      end

      case ({do_enq, inj_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (!dout_valid || inj_fire) begin
        starve_cnt <= 8'd0;
      end else if (starve_cnt != 8'hFF) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
    end
  end

endmodule
